// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_pkg;

  localparam int unsigned UART_BYTE_W    = 8;
  localparam int unsigned START_WAIT_DEF = 16;
  localparam int unsigned GAP_CYCLES_DEF = 2;

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StLoad,
    StStart,
    StWaitHi,
    StWaitLo,
    StGap
  } arb_state_e;

  // Next round-robin position after idx, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned PtrW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PtrW-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [PtrW-1:0]  idx_o,
  output logic             valid_o
);

  logic [PtrW-1:0] j;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      j = PtrW'((32'(ptr_i) + k) % N_REQ);
      if (!valid_o && req_i[j]) begin
        valid_o  = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter in front of a single UART transmitter byte port.
// Build option: define UART_ARB_TIMEOUT_EN to abort packets stalled for IDLE_TO cycles.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned START_WAIT = START_WAIT_DEF,
  parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int unsigned IDLE_TO    = 1024
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [UART_BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]             req_last,
  output logic [N_REQ-1:0]             req_ready,
  output logic [N_REQ-1:0]             grant,
  output logic [UART_BYTE_W-1:0]       tx_data,
  output logic                         tx_start,
  input  logic                         tx_busy,
  output logic                         err_to
);

  localparam int unsigned PtrW   = $clog2(N_REQ);
  localparam int unsigned CntMax = (START_WAIT > GAP_CYCLES) ? START_WAIT : GAP_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("uart_tx_arbiter: N_REQ must be in 2..8");
  end
  if (START_WAIT == 0) begin : g_bad_start_wait
    $error("uart_tx_arbiter: START_WAIT must be nonzero");
  end
  if (IDLE_TO == 0) begin : g_bad_idle_to
    $error("uart_tx_arbiter: IDLE_TO must be nonzero");
  end

  arb_state_e             state_q, state_d;
  logic [N_REQ-1:0]       grant_q, grant_d;
  logic [PtrW-1:0]        gidx_q, gidx_d;
  logic [PtrW-1:0]        ptr_q, ptr_d;
  logic [N_REQ-1:0]       req_ready_q, req_ready_d;
  logic [UART_BYTE_W-1:0] tx_data_q, tx_data_d;
  logic                   tx_start_q, tx_start_d;
  logic                   last_q, last_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   byte_done;

  logic [UART_BYTE_W-1:0] sel_data;
  logic                   sel_valid;
  logic                   sel_last;

  logic [N_REQ-1:0] arb_gnt;
  logic [PtrW-1:0]  arb_idx;
  logic             arb_valid;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(IDLE_TO + 1);
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           err_to_q, err_to_d;
`endif

  // Byte lane of the current owner; only meaningful while grant_q is set.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gidx_q == PtrW'(i)) begin
        sel_data  = req_data[i*UART_BYTE_W +: UART_BYTE_W];
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
      end
    end
  end

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_rr_arbiter (
    .req_i  (req_valid),
    .ptr_i  (ptr_q),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx),
    .valid_o(arb_valid)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    ptr_d       = ptr_q;
    req_ready_d = '0;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    last_d      = last_q;
    cnt_d       = cnt_q;
    byte_done   = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    err_to_d = 1'b0;
    to_cnt_d = (state_q == StLoad && !sel_valid && to_cnt_q != ToW'(IDLE_TO - 1)) ?
               to_cnt_q + 1'b1 : '0;
`endif

    unique case (state_q)
      StIdle: begin
        if (|req_valid) state_d = StArb;
      end
      StArb: begin
        // Requests may have been withdrawn since IDLE saw them.
        if (arb_valid) begin
          grant_d = arb_gnt;
          gidx_d  = arb_idx;
          state_d = StLoad;
        end else begin
          state_d = StIdle;
        end
      end
      StLoad: begin
        if (sel_valid) begin
          tx_data_d   = sel_data;
          req_ready_d = grant_q;
          last_d      = sel_last;
          tx_start_d  = 1'b1;
          state_d     = StStart;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (to_cnt_q == ToW'(IDLE_TO - 1)) begin
          err_to_d = 1'b1;
          grant_d  = '0;
          ptr_d    = PtrW'(rr_next(32'(gidx_q), N_REQ));
          state_d  = StIdle;
        end
`endif
      end
      StStart: begin
        cnt_d   = '0;
        state_d = StWaitHi;
      end
      StWaitHi: begin
        // No busy within the window means the core dropped the start; re-issue it.
        if (tx_busy) begin
          state_d = StWaitLo;
        end else if (cnt_q == CntW'(START_WAIT - 1)) begin
          tx_start_d = 1'b1;
          state_d    = StStart;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitLo: begin
        if (!tx_busy) begin
          if (GAP_CYCLES == 0) begin
            byte_done = 1'b1;
          end else begin
            cnt_d   = '0;
            state_d = StGap;
          end
        end
      end
      StGap: begin
        if (cnt_q == CntW'(GAP_CYCLES - 1)) byte_done = 1'b1;
        else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (byte_done) begin
      if (last_q) begin
        grant_d = '0;
        ptr_d   = PtrW'(rr_next(32'(gidx_q), N_REQ));
        state_d = StIdle;
      end else begin
        state_d = StLoad;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      gidx_q      <= '0;
      ptr_q       <= '0;
      req_ready_q <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      last_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      ptr_q       <= ptr_d;
      req_ready_q <= req_ready_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_q <= '0;
      err_to_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_to_q <= err_to_d;
    end
  end
  assign err_to = err_to_q;
`else
  assign err_to = 1'b0;
`endif

  assign grant     = grant_q;
  assign req_ready = req_ready_q;
  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;

endmodule
